// File: rtl/ifu_pkg.sv
// Shared opcodes, FSM states and instruction/decode types for the
// instruction fetch unit.
package ifu_pkg;
  localparam logic [3:0]  INSTR_SEL = 4'b1000;
  localparam int          PC_W      = 12;
  localparam logic [11:0] PC_LAST   = 12'h009;

  localparam logic [7:0] OP_MMULT     = 8'h00;
  localparam logic [7:0] OP_MADD      = 8'h01;
  localparam logic [7:0] OP_MSUB      = 8'h02;
  localparam logic [7:0] OP_MTRANS    = 8'h03;
  localparam logic [7:0] OP_MSCALE    = 8'h04;
  localparam logic [7:0] OP_MSCALEIMM = 8'h05;
  localparam logic [7:0] OP_INTADD    = 8'h10;
  localparam logic [7:0] OP_INTSUB    = 8'h11;
  localparam logic [7:0] OP_INTMUL    = 8'h12;
  localparam logic [7:0] OP_INTDIV    = 8'h13;
  localparam logic [7:0] OP_STOP      = 8'hFF;

  typedef enum logic [2:0] {IDLE, REQ, WAIT, DEC, ISSUE, HALT} state_t;

  typedef struct packed {
    logic [7:0] opcode;
    logic [7:0] dest;
    logic [7:0] src1;
    logic [7:0] src2;
  } instr_t;

  typedef struct packed {
    logic is_matrix;
    logic is_integer;
    logic src2_imm;
    logic dest_reg;
    logic src1_reg;
    logic src2_reg;
    logic is_stop;
    logic is_illegal;
  } dec_t;
endpackage

// File: rtl/instr_decoder.sv
// Combinational classifier: opcode class, immediate form and register/memory
// selection for each operand field.
module instr_decoder
  import ifu_pkg::*;
(
  input  instr_t i_instr,
  output dec_t   o_dec
);
  always_comb begin
    o_dec            = '0;
    o_dec.is_matrix  = (i_instr.opcode <= OP_MSCALEIMM);
    o_dec.is_integer = (i_instr.opcode >= OP_INTADD) && (i_instr.opcode <= OP_INTDIV);
    o_dec.src2_imm   = (i_instr.opcode == OP_MSCALEIMM);
    o_dec.dest_reg   = i_instr.dest[7];
    o_dec.src1_reg   = i_instr.src1[7];
    // an immediate Src2 never names a register, whatever its top bit
    o_dec.src2_reg   = i_instr.src2[7] & ~o_dec.src2_imm;
    o_dec.is_stop    = (i_instr.opcode == OP_STOP);
    o_dec.is_illegal = ~(o_dec.is_matrix | o_dec.is_integer | o_dec.is_stop);
  end
endmodule

// File: rtl/instruction_fetch_unit.sv
// Fetch/decode/issue sequencer: reads one instruction word per pass, decodes
// it and hands it to the execution engine over a valid/ready handshake.
module instruction_fetch_unit #(
  parameter logic [3:0]      INSTR_SEL = ifu_pkg::INSTR_SEL,
  parameter int              PC_W      = ifu_pkg::PC_W,
  parameter logic [PC_W-1:0] PC_LAST   = PC_W'(ifu_pkg::PC_LAST)
) (
  input  logic            Clk,
  input  logic            Reset,
  input  logic            Start,
  output logic [15:0]     address,
  output logic            nRead,
  input  logic [255:0]    InstrData,
  output logic            IssueValid,
  input  logic            IssueReady,
  output logic [7:0]      Opcode,
  output logic [7:0]      Dest,
  output logic [7:0]      Src1,
  output logic [7:0]      Src2,
  output logic            IsMatrix,
  output logic            IsInteger,
  output logic            Src2Imm,
  output logic            DestReg,
  output logic            Src1Reg,
  output logic            Src2Reg,
  output logic [PC_W-1:0] Pc,
  output logic            Halted,
  output logic            Illegal
);
  import ifu_pkg::*;

  state_t          r_state, w_next;
  instr_t          r_instr, r_out;
  dec_t            w_dec;
  logic [PC_W-1:0] r_pc;
  logic            r_is_matrix, r_is_integer, r_src2_imm;
  logic            r_dest_reg, r_src1_reg, r_src2_reg, r_illegal;
  logic            w_start_ok, w_hs, w_req;
  logic            w_unused;

  assign w_unused   = ^InstrData[255:32];
  assign w_start_ok = Start && (r_state == IDLE || r_state == HALT);
  assign w_hs       = (r_state == ISSUE) && IssueReady;

  instr_decoder u_dec (
    .i_instr (r_instr),
    .o_dec   (w_dec)
  );

  always_ff @(posedge Clk) begin
    if (Reset) r_state <= IDLE;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (Start) w_next = REQ;
      REQ:     w_next = WAIT;
      WAIT:    w_next = DEC;
      DEC:     w_next = (w_dec.is_matrix || w_dec.is_integer) ? ISSUE : HALT;
      ISSUE:   if (IssueReady) w_next = REQ;
      HALT:    if (Start) w_next = REQ;
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      r_pc         <= '0;
      r_instr      <= '0;
      r_out        <= '0;
      r_is_matrix  <= 1'b0;
      r_is_integer <= 1'b0;
      r_src2_imm   <= 1'b0;
      r_dest_reg   <= 1'b0;
      r_src1_reg   <= 1'b0;
      r_src2_reg   <= 1'b0;
      r_illegal    <= 1'b0;
    end else begin
      if (w_start_ok) begin
        r_pc      <= '0;
        r_illegal <= 1'b0;
      end
      if (r_state == WAIT) r_instr <= instr_t'(InstrData[31:0]);
      // issue outputs only change here, so they hold steady through ISSUE
      if (r_state == DEC) begin
        r_out        <= r_instr;
        r_is_matrix  <= w_dec.is_matrix;
        r_is_integer <= w_dec.is_integer;
        r_src2_imm   <= w_dec.src2_imm;
        r_dest_reg   <= w_dec.dest_reg;
        r_src1_reg   <= w_dec.src1_reg;
        r_src2_reg   <= w_dec.src2_reg;
        if (w_dec.is_illegal) r_illegal <= 1'b1;
      end
      if (w_hs) r_pc <= (r_pc == PC_LAST) ? '0 : r_pc + PC_W'(1);
    end
  end

  // Reset drops the read strobe in the same cycle rather than after the edge
  assign w_req      = (r_state == REQ) && !Reset;
  assign nRead      = ~w_req;
  assign address    = w_req ? 16'({INSTR_SEL, r_pc}) : 16'h0000;
  assign IssueValid = (r_state == ISSUE);
  assign Halted     = (r_state == HALT);
  assign Illegal    = r_illegal;
  assign Pc         = r_pc;
  assign Opcode     = r_out.opcode;
  assign Dest       = r_out.dest;
  assign Src1       = r_out.src1;
  assign Src2       = r_out.src2;
  assign IsMatrix   = r_is_matrix;
  assign IsInteger  = r_is_integer;
  assign Src2Imm    = r_src2_imm;
  assign DestReg    = r_dest_reg;
  assign Src1Reg    = r_src1_reg;
  assign Src2Reg    = r_src2_reg;
endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Directed bench for instruction_fetch_unit with a 1-cycle registered
// instruction memory model.
module tb_instruction_fetch_unit;
  logic         Clk, Reset, Start, nRead, IssueValid, IssueReady;
  logic [15:0]  address;
  logic [255:0] InstrData;
  logic [7:0]   Opcode, Dest, Src1, Src2;
  logic         IsMatrix, IsInteger, Src2Imm, DestReg, Src1Reg, Src2Reg;
  logic [11:0]  Pc;
  logic         Halted, Illegal;

  int checks = 0;
  int errors = 0;
  int nread_cnt = 0;
  logic [15:0] last_addr = '0;
  logic [31:0] mem [0:15];

  instruction_fetch_unit dut (
    .Clk(Clk), .Reset(Reset), .Start(Start), .address(address), .nRead(nRead),
    .InstrData(InstrData), .IssueValid(IssueValid), .IssueReady(IssueReady),
    .Opcode(Opcode), .Dest(Dest), .Src1(Src1), .Src2(Src2),
    .IsMatrix(IsMatrix), .IsInteger(IsInteger), .Src2Imm(Src2Imm),
    .DestReg(DestReg), .Src1Reg(Src1Reg), .Src2Reg(Src2Reg),
    .Pc(Pc), .Halted(Halted), .Illegal(Illegal)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  always @(posedge Clk)
    if (!nRead && address[15:12] == 4'b1000)
      InstrData <= {224'b0, mem[address[3:0]]};

  always @(negedge Clk)
    if (!nRead) begin
      nread_cnt++;
      last_addr = address;
    end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic pulse_start();
    Start = 1'b1;
    tick();
    Start = 1'b0;
  endtask

  // from REQ: run to ISSUE, check the word at index k, then handshake
  task automatic issue_one(input int k);
    logic [31:0] w;
    w = mem[k];
    tick(); tick(); tick();
    chk("issue_valid", IssueValid, 1);
    chk("issue_pc", Pc, k);
    chk("issue_op", Opcode, w[31:24]);
    IssueReady = 1'b1;
    tick();
    IssueReady = 1'b0;
  endtask

  initial begin
    Reset = 1'b1; Start = 1'b0; IssueReady = 1'b0; InstrData = '0;
    mem[0] = 32'h01_02_00_01; mem[1] = 32'h11_0A_01_81; mem[2] = 32'h05_07_00_64;
    mem[3] = 32'h02_80_00_00; mem[4] = 32'h03_00_80_00; mem[5] = 32'h04_00_00_80;
    mem[6] = 32'h10_01_02_03; mem[7] = 32'h12_00_00_00; mem[8] = 32'h13_00_00_00;
    mem[9] = 32'h00_00_00_00;
    for (int i = 10; i < 16; i++) mem[i] = 32'hFF_00_00_00;
    tick(); tick();
    Reset = 1'b0;
    chk("rst_valid", IssueValid, 0);
    chk("rst_nread", nRead, 1);
    chk("rst_addr", address, 16'h0000);
    chk("rst_pc", Pc, 0);
    chk("rst_halted", Halted, 0);
    chk("rst_illegal", Illegal, 0);
    chk("rst_fields", {Opcode, Dest, Src1, Src2}, 0);
    chk("rst_flags", {IsMatrix, IsInteger, Src2Imm, DestReg, Src1Reg, Src2Reg}, 0);

    // 1: first fetch and latency
    nread_cnt = 0;
    pulse_start();
    chk("req_nread", nRead, 0);
    chk("req_addr", address, 16'h8000);
    tick();
    chk("wait_nread", nRead, 1);
    chk("wait_addr", address, 16'h0000);
    tick();
    chk("dec_valid", IssueValid, 0);
    tick();
    chk("t1_valid", IssueValid, 1);
    chk("t1_fields", {Opcode, Dest, Src1, Src2}, 32'h01_02_00_01);
    chk("t1_ismatrix", IsMatrix, 1);
    chk("t1_isint", IsInteger, 0);
    chk("t1_regs", {DestReg, Src1Reg, Src2Reg}, 0);
    chk("t1_nread_cnt", nread_cnt, 1);
    chk("t1_last_addr", last_addr, 16'h8000);

    // 2: stall, then handshake
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("stall_valid", IssueValid, 1);
      chk("stall_fields", {Opcode, Dest, Src1, Src2}, 32'h01_02_00_01);
    end
    IssueReady = 1'b1;
    tick();
    IssueReady = 1'b0;
    chk("hs_valid", IssueValid, 0);
    chk("hs_pc", Pc, 1);
    chk("hs_addr", address, 16'h8001);

    // 3: integer op and immediate op
    tick(); tick(); tick();
    chk("t3_fields", {Opcode, Dest, Src1, Src2}, 32'h11_0A_01_81);
    chk("t3_flags", {IsMatrix, IsInteger, Src2Imm}, 3'b010);
    chk("t3_regs", {DestReg, Src1Reg, Src2Reg}, 3'b001);
    IssueReady = 1'b1; tick(); IssueReady = 1'b0;
    tick(); tick(); tick();
    chk("t3b_flags", {IsMatrix, IsInteger, Src2Imm}, 3'b101);
    chk("t3b_src2reg", Src2Reg, 0);
    chk("t3b_src2", Src2, 8'h64);

    // 4: STOP halts with Pc frozen
    Reset = 1'b1; tick(); Reset = 1'b0;
    mem[2] = 32'hFF_0A_00_01;
    pulse_start();
    issue_one(0);
    issue_one(1);
    tick(); tick(); tick();
    chk("stop_halted", Halted, 1);
    chk("stop_valid", IssueValid, 0);
    chk("stop_illegal", Illegal, 0);
    chk("stop_pc", Pc, 2);
    tick(); tick();
    chk("stop_hold", {Halted, IssueValid, 12'(Pc)}, {1'b1, 1'b0, 12'd2});
    mem[0] = 32'h20_00_00_00;
    pulse_start();
    chk("restart_pc", Pc, 0);
    chk("restart_addr", address, 16'h8000);
    chk("restart_halted", Halted, 0);

    // 5: illegal opcode
    tick(); tick();
    chk("ill_dec_valid", IssueValid, 0);
    tick();
    chk("ill_halted", Halted, 1);
    chk("ill_flag", Illegal, 1);
    chk("ill_valid", IssueValid, 0);
    pulse_start();
    chk("ill_clear", Illegal, 0);
    chk("ill_unhalt", Halted, 0);

    // 6: reset in REQ/WAIT/ISSUE, Start+Reset, then wrap
    mem[0] = 32'h01_02_00_01; mem[2] = 32'h05_07_00_64;
    Reset = 1'b1;
    #1;
    chk("rst_req_nread", nRead, 1);
    Reset = 1'b0;
    tick();
    pulse_start();
    tick();
    Reset = 1'b1; tick(); Reset = 1'b0;
    chk("rstw_valid", IssueValid, 0);
    chk("rstw_nread", nRead, 1);
    chk("rstw_pc", Pc, 0);
    tick();
    chk("rstw_idle", {nRead, Halted, IssueValid}, 3'b100);
    pulse_start();
    tick(); tick(); tick();
    chk("rsti_pre_valid", IssueValid, 1);
    Reset = 1'b1; tick(); Reset = 1'b0;
    chk("rsti_valid", IssueValid, 0);
    chk("rsti_pc", Pc, 0);
    chk("rsti_fields", {Opcode, Dest, Src1, Src2}, 0);
    Reset = 1'b1; Start = 1'b1; tick(); Reset = 1'b0; Start = 1'b0;
    tick();
    chk("rst_start_idle", nRead, 1);
    pulse_start();
    for (int k = 0; k < 10; k++) issue_one(k);
    chk("wrap_pc", Pc, 0);
    chk("wrap_addr", address, 16'h8000);
    chk("wrap_halted", Halted, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
